// File: rtl/cv_ctrl_pkg.sv
// rtl/cv_ctrl_pkg.sv - shared constants and FSM state type for the ColecoVision controller scanner
// Keypad nibble codes are {p1,p2,p3,p4}, MSB first, as seen on the active-low lines.
package cv_ctrl_pkg;

  localparam logic [3:0] cv_key_0_c      = 4'b0011;
  localparam logic [3:0] cv_key_1_c      = 4'b1110;
  localparam logic [3:0] cv_key_2_c      = 4'b1101;
  localparam logic [3:0] cv_key_3_c      = 4'b0110;
  localparam logic [3:0] cv_key_4_c      = 4'b0001;
  localparam logic [3:0] cv_key_5_c      = 4'b1001;
  localparam logic [3:0] cv_key_6_c      = 4'b0111;
  localparam logic [3:0] cv_key_7_c      = 4'b1100;
  localparam logic [3:0] cv_key_8_c      = 4'b1000;
  localparam logic [3:0] cv_key_9_c      = 4'b1011;
  localparam logic [3:0] cv_key_star_c   = 4'b1010;
  localparam logic [3:0] cv_key_hash_c   = 4'b0101;
  localparam logic [3:0] cv_key_purple_c = 4'b0100;
  localparam logic [3:0] cv_key_blue_c   = 4'b0010;

  localparam int key_w_c          = 14;
  localparam int key_star_idx_c   = 10;
  localparam int key_hash_idx_c   = 11;
  localparam int key_purple_idx_c = 12;
  localparam int key_blue_idx_c   = 13;

  localparam int joy_w_c      = 20;
  localparam int joy_r_c      = 0;
  localparam int joy_l_c      = 1;
  localparam int joy_d_c      = 2;
  localparam int joy_u_c      = 3;
  localparam int joy_f1_c     = 4;
  localparam int joy_f2_c     = 5;
  localparam int joy_star_c   = 6;
  localparam int joy_hash_c   = 7;
  localparam int joy_dig0_c   = 8;
  localparam int joy_purple_c = 18;
  localparam int joy_blue_c   = 19;

  typedef enum logic [2:0] {
    IDLE,
    KP_SEL,
    KP_SMP,
    JY_SEL,
    JY_SMP
  } scan_state_e;

endpackage

// File: rtl/cv_keypad_decode.sv
// rtl/cv_keypad_decode.sv - keypad nibble to one-hot key vector
// Bits 0..9 are digits, then star, hash, purple, blue; unknown codes give no key.
module cv_keypad_decode
  import cv_ctrl_pkg::*;
(
  input  logic [3:0]         nib_i,
  output logic [key_w_c-1:0] key_o
);

  always_comb begin
    key_o = '0;
    case (nib_i)
      cv_key_0_c:      key_o[0] = 1'b1;
      cv_key_1_c:      key_o[1] = 1'b1;
      cv_key_2_c:      key_o[2] = 1'b1;
      cv_key_3_c:      key_o[3] = 1'b1;
      cv_key_4_c:      key_o[4] = 1'b1;
      cv_key_5_c:      key_o[5] = 1'b1;
      cv_key_6_c:      key_o[6] = 1'b1;
      cv_key_7_c:      key_o[7] = 1'b1;
      cv_key_8_c:      key_o[8] = 1'b1;
      cv_key_9_c:      key_o[9] = 1'b1;
      cv_key_star_c:   key_o[key_star_idx_c] = 1'b1;
      cv_key_hash_c:   key_o[key_hash_idx_c] = 1'b1;
      cv_key_purple_c: key_o[key_purple_idx_c] = 1'b1;
      cv_key_blue_c:   key_o[key_blue_idx_c] = 1'b1;
      default:         key_o = '0;
    endcase
  end

endmodule

// File: rtl/cv_ctrl_scanner.sv
// rtl/cv_ctrl_scanner.sv - scans both ColecoVision ports, decodes and debounces into joystick words
// Both ports share one select sequencer; decode and debounce are replicated per port.
module cv_ctrl_scanner
  import cv_ctrl_pkg::*;
#(
  parameter int SETTLE   = 8,
  parameter int GAP      = 64,
  parameter int DEBOUNCE = 2
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ce,
  input  logic                en_i,
  input  logic [1:0]          p1_i,
  input  logic [1:0]          p2_i,
  input  logic [1:0]          p3_i,
  input  logic [1:0]          p4_i,
  input  logic [1:0]          p6_i,
  output logic [1:0]          p5_o,
  output logic [1:0]          p8_o,
  output logic [joy_w_c-1:0]  joy0_o,
  output logic [joy_w_c-1:0]  joy1_o,
  output logic                upd_o
);

  localparam int cnt_max_c = (SETTLE > GAP) ? SETTLE : GAP;
  localparam int cnt_w_c   = $clog2(cnt_max_c + 1);

  scan_state_e                     state_q, state_d;
  logic [cnt_w_c-1:0]              cnt_q, cnt_d;
  logic [1:0]                      p5_q, p5_d, p8_q, p8_d;
  logic [1:0][3:0]                 kp_nib_q, kp_nib_d;
  logic [1:0]                      kp_fire_q, kp_fire_d;
  logic [1:0][joy_w_c-1:0]         prev_q, prev_d;
  logic [1:0][2:0]                 deb_q, deb_d;
  logic [1:0][joy_w_c-1:0]         joy_q, joy_d;
  logic                            upd_q, upd_d;

  logic                            scan_done;
  logic [1:0]                      commit;
  logic [1:0][key_w_c-1:0]         key;
  logic [1:0][joy_w_c-1:0]         cand;

  for (genvar g = 0; g < 2; g++) begin : g_dec
    cv_keypad_decode u_dec (
      .nib_i (kp_nib_q[g]),
      .key_o (key[g])
    );
  end

  // Joystick lines are taken live on the JY_SMP tick; keypad lines were latched one phase earlier.
  always_comb begin
    cand = '0;
    for (int i = 0; i < 2; i++) begin
      cand[i][joy_dig0_c +: 10]  = key[i][9:0];
      cand[i][joy_star_c]        = key[i][key_star_idx_c];
      cand[i][joy_hash_c]        = key[i][key_hash_idx_c];
      cand[i][joy_purple_c]      = key[i][key_purple_idx_c];
      cand[i][joy_blue_c]        = key[i][key_blue_idx_c];
      cand[i][joy_f2_c]          = ~kp_fire_q[i];
      cand[i][joy_u_c]           = ~p1_i[i];
      cand[i][joy_d_c]           = ~p2_i[i];
      cand[i][joy_l_c]           = ~p3_i[i];
      cand[i][joy_r_c]           = ~p4_i[i];
      cand[i][joy_f1_c]          = ~p6_i[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    kp_nib_d  = kp_nib_q;
    kp_fire_d = kp_fire_q;
    scan_done = 1'b0;
    if (ce) begin
      case (state_q)
        IDLE: begin
          if (!en_i) begin
            cnt_d = '0;
          end else if ((int'(cnt_q) + 1) >= GAP) begin
            state_d = KP_SEL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        KP_SEL: begin
          if ((int'(cnt_q) + 1) >= SETTLE) begin
            state_d = KP_SMP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        KP_SMP: begin
          for (int i = 0; i < 2; i++) begin
            kp_nib_d[i] = {p1_i[i], p2_i[i], p3_i[i], p4_i[i]};
          end
          kp_fire_d = p6_i;
          state_d   = JY_SEL;
        end
        JY_SEL: begin
          if ((int'(cnt_q) + 1) >= SETTLE) begin
            state_d = JY_SMP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        JY_SMP: begin
          scan_done = 1'b1;
          // With no gap the idle state is skipped so the period stays 2*(SETTLE+1).
          state_d   = (GAP == 0 && en_i) ? KP_SEL : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    p5_d = (state_d == KP_SEL || state_d == KP_SMP) ? 2'b00 : 2'b11;
    p8_d = (state_d == JY_SEL || state_d == JY_SMP) ? 2'b00 : 2'b11;
  end

  always_comb begin
    prev_d = prev_q;
    deb_d  = deb_q;
    joy_d  = joy_q;
    commit = '0;
    if (scan_done) begin
      for (int i = 0; i < 2; i++) begin
        prev_d[i] = cand[i];
        if (cand[i] == prev_q[i]) begin
          deb_d[i] = (deb_q[i] == 3'd7) ? 3'd7 : deb_q[i] + 3'd1;
        end else begin
          deb_d[i] = 3'd1;
        end
        if (deb_d[i] == 3'(DEBOUNCE) && cand[i] != joy_q[i]) begin
          joy_d[i]  = cand[i];
          commit[i] = 1'b1;
        end
      end
    end
    upd_d = |commit;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      p5_q      <= 2'b11;
      p8_q      <= 2'b11;
      kp_nib_q  <= '1;
      kp_fire_q <= 2'b11;
      prev_q    <= '0;
      deb_q     <= '0;
      joy_q     <= '0;
      upd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p5_q      <= p5_d;
      p8_q      <= p8_d;
      kp_nib_q  <= kp_nib_d;
      kp_fire_q <= kp_fire_d;
      prev_q    <= prev_d;
      deb_q     <= deb_d;
      joy_q     <= joy_d;
      upd_q     <= upd_d;
    end
  end

  assign p5_o   = p5_q;
  assign p8_o   = p8_q;
  assign joy0_o = joy_q[0];
  assign joy1_o = joy_q[1];
  assign upd_o  = upd_q;

endmodule

// File: tb/tb_cv_ctrl_scanner.sv
// tb/tb_cv_ctrl_scanner.sv - directed bench for cv_ctrl_scanner with a two-port controller model
// Small SETTLE/GAP keep scans short; ce ticks every other clock.
module tb_cv_ctrl_scanner;

  localparam int SETTLE   = 2;
  localparam int GAP      = 3;
  localparam int DEBOUNCE = 2;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        ce      = 1'b0;
  logic        en_i    = 1'b1;
  logic [1:0]  p1_i, p2_i, p3_i, p4_i, p6_i;
  logic [1:0]  p5_o, p8_o;
  logic [19:0] joy0_o, joy1_o;
  logic        upd_o;

  logic [1:0][3:0] kp_nib = '1;
  logic [1:0]      kp_f   = 2'b11;
  logic [1:0][3:0] jy     = '1;
  logic [1:0]      jy_f   = 2'b11;

  int n_total = 0;
  int n_bad   = 0;
  int scan_ends = 0;
  int upd_cnt   = 0;
  int excl_bad  = 0;
  logic [1:0] p8_prev = 2'b11;

  cv_ctrl_scanner #(.SETTLE(SETTLE), .GAP(GAP), .DEBOUNCE(DEBOUNCE)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ce      (ce),
    .en_i    (en_i),
    .p1_i    (p1_i),
    .p2_i    (p2_i),
    .p3_i    (p3_i),
    .p4_i    (p4_i),
    .p6_i    (p6_i),
    .p5_o    (p5_o),
    .p8_o    (p8_o),
    .joy0_o  (joy0_o),
    .joy1_o  (joy1_o),
    .upd_o   (upd_o)
  );

  initial forever #5 clk_sys = ~clk_sys;
  initial forever begin
    @(negedge clk_sys);
    ce = ~ce;
  end

  // Controller model: lines answer whichever select is low, else float high.
  always_comb begin
    p1_i = 2'b11; p2_i = 2'b11; p3_i = 2'b11; p4_i = 2'b11; p6_i = 2'b11;
    for (int i = 0; i < 2; i++) begin
      if (!p5_o[i]) begin
        {p1_i[i], p2_i[i], p3_i[i], p4_i[i]} = kp_nib[i];
        p6_i[i] = kp_f[i];
      end else if (!p8_o[i]) begin
        {p1_i[i], p2_i[i], p3_i[i], p4_i[i]} = jy[i];
        p6_i[i] = jy_f[i];
      end
    end
  end

  always @(negedge clk_sys) begin
    if (p8_prev != 2'b11 && p8_o == 2'b11) scan_ends <= scan_ends + 1;
    if (upd_o) upd_cnt <= upd_cnt + 1;
    if ((p5_o | p8_o) != 2'b11) excl_bad <= excl_bad + 1;
    p8_prev <= p8_o;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_port(input int i, input logic [3:0] nib, input logic kpf,
                          input logic [3:0] j, input logic jf);
    kp_nib[i] = nib;
    kp_f[i]   = kpf;
    jy[i]     = j;
    jy_f[i]   = jf;
  endtask

  task automatic wait_scans(input int n, input string tag);
    int tgt;
    tgt = scan_ends + n;
    for (int k = 0; k < 2000 && scan_ends < tgt; k++) begin
      @(negedge clk_sys);
      #1;
    end
    check_val({tag, "_scan"}, 32'(scan_ends >= tgt), 32'd1);
  endtask

  task automatic expect_after(input int scans, input logic [19:0] e0, input logic [19:0] e1,
                              input int dupd, input string tag);
    int u0;
    u0 = upd_cnt;
    wait_scans(scans, tag);
    repeat (2) @(negedge clk_sys);
    #1;
    check_val({tag, "_j0"}, 32'(joy0_o), 32'(e0));
    check_val({tag, "_j1"}, 32'(joy1_o), 32'(e1));
    check_val({tag, "_upd"}, upd_cnt - u0, dupd);
  endtask

  task automatic ticks_to_kp(output int t);
    t = 0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk_sys);
      if (ce) t++;
      #1;
      if (p5_o == 2'b00) break;
    end
  endtask

  initial begin
    int t;
    int s0;
    #12;
    check_val("rst_p5", 32'(p5_o), 32'h3);
    check_val("rst_p8", 32'(p8_o), 32'h3);
    check_val("rst_j0", 32'(joy0_o), 32'h0);
    check_val("rst_j1", 32'(joy1_o), 32'h0);
    check_val("rst_upd", 32'(upd_o), 32'h0);
    @(negedge clk_sys);
    reset = 1'b0;

    expect_after(3, 20'h0, 20'h0, 0, "idle");

    set_port(0, 4'b1001, 1'b1, 4'hF, 1'b1);
    expect_after(1, 20'h0, 20'h0, 0, "k5_a");
    expect_after(1, 20'h02000, 20'h0, 1, "k5_b");
    set_port(0, 4'hF, 1'b1, 4'hF, 1'b1);
    expect_after(2, 20'h0, 20'h0, 1, "k5_rel");

    set_port(0, 4'b1110, 1'b1, 4'hF, 1'b1);
    expect_after(2, 20'h00200, 20'h0, 1, "k1");

    set_port(0, 4'hF, 1'b1, 4'hF, 1'b1);
    set_port(1, 4'hF, 1'b1, 4'b0111, 1'b0);
    expect_after(2, 20'h0, 20'h00018, 1, "up_fire");
    expect_after(1, 20'h0, 20'h00018, 0, "up_hold");

    set_port(0, 4'b1010, 1'b0, 4'hF, 1'b1);
    set_port(1, 4'b0100, 1'b1, 4'b0000, 1'b1);
    expect_after(2, 20'h00060, 20'h4000F, 1, "star_purple");

    set_port(0, 4'hF, 1'b1, 4'hF, 1'b1);
    set_port(1, 4'b0010, 1'b1, 4'hF, 1'b1);
    expect_after(2, 20'h0, 20'h80000, 1, "blue");
    set_port(1, 4'hF, 1'b1, 4'hF, 1'b1);
    expect_after(2, 20'h0, 20'h0, 1, "rel_all");

    set_port(0, 4'b0101, 1'b1, 4'hF, 1'b1);
    expect_after(1, 20'h0, 20'h0, 0, "hash_1");
    set_port(0, 4'hF, 1'b1, 4'hF, 1'b1);
    expect_after(2, 20'h0, 20'h0, 0, "hash_gone");

    set_port(0, 4'b0000, 1'b1, 4'hF, 1'b1);
    expect_after(2, 20'h0, 20'h0, 0, "nib0000");

    set_port(0, 4'b1011, 1'b1, 4'hF, 1'b1);
    expect_after(2, 20'h20000, 20'h0, 1, "k9");

    for (int k = 0; k < 400 && p8_o != 2'b00; k++) begin
      @(negedge clk_sys);
      #1;
    end
    check_val("jysel_seen", 32'(p8_o), 32'h0);
    #1;
    reset = 1'b1;
    #1;
    check_val("arst_p8", 32'(p8_o), 32'h3);
    check_val("arst_p5", 32'(p5_o), 32'h3);
    check_val("arst_j0", 32'(joy0_o), 32'h0);
    check_val("arst_upd", 32'(upd_o), 32'h0);
    set_port(0, 4'hF, 1'b1, 4'hF, 1'b1);
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    ticks_to_kp(t);
    check_val("gap_after_rst", t, GAP);

    for (int k = 0; k < 400 && p5_o != 2'b00; k++) begin
      @(negedge clk_sys);
      #1;
    end
    en_i = 1'b0;
    s0 = scan_ends;
    wait_scans(1, "en_off");
    repeat (60) @(negedge clk_sys);
    #1;
    check_val("en_off_scans", scan_ends - s0, 1);
    check_val("en_off_p5", 32'(p5_o), 32'h3);
    check_val("en_off_p8", 32'(p8_o), 32'h3);
    en_i = 1'b1;
    ticks_to_kp(t);
    check_val("gap_after_en", t, GAP);

    check_val("excl", excl_bad, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
